uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 8, number of FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter: LW, default $clog2(DEPTH)+1, width of the level/watermark fields.
REQ-003 Ports SHALL be:
- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_done  input  1  one-cycle strobe from the UART receiver when a frame completes.
- rx_data  input  8  received byte, valid while rx_done=1.
- rx_frame_error  input  1  frame (stop-bit) error of the frame, valid while rx_done=1.
- rx_parity_error  input  1  parity error of the frame, valid while rx_done=1.
- drop_errored  input  1  1 = discard frames with either error flag set.
- flush  input  1  1 = empty the FIFO.
- rd_en  input  1  pop request from the bus side.
- rd_data  output  8  head-entry byte.
- rd_frame_error  output  1  head-entry frame error.
- rd_parity_error  output  1  head-entry parity error.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- level  output  LW  number of stored entries, 0..DEPTH.
- watermark  input  LW  interrupt threshold.
- rxwm_irq  output  1  watermark interrupt.
- overrun  output  1  sticky overflow flag.
- overrun_clr  input  1  clears overrun.

Function
REQ-004 Storage SHALL be DEPTH entries of 10 bits: {parity_error, frame_error, data[7:0]}, with wrapping read and write pointers of $clog2(DEPTH) bits.
REQ-005 A push SHALL be attempted when rx_done=1, except when drop_errored=1 and (rx_frame_error|rx_parity_error)=1; such a frame is silently dropped with no other effect.
REQ-006 An attempted push SHALL be accepted when full=0, or when full=1 and a pop is accepted in the same cycle.
REQ-007 A pop SHALL be accepted when rd_en=1 and empty=0; rd_en with empty=1 SHALL be ignored with no state change.
REQ-008 Each accepted push SHALL write the entry at the write pointer and increment the pointer modulo DEPTH.
REQ-009 Each accepted pop SHALL increment the read pointer modulo DEPTH.
REQ-010 level SHALL update as follows: +1 for push only, -1 for pop only, unchanged when a push and pop are accepted in the same cycle.
REQ-011 Show-ahead read: rd_data, rd_frame_error and rd_parity_error SHALL present the head entry whenever empty=0; all three SHALL be 0 whenever empty=1.
REQ-012 Latency: an entry pushed into an empty FIFO SHALL appear on rd_data, with empty=0, in the cycle after rx_done.
REQ-013 empty SHALL equal (level==0); full SHALL equal (level==DEPTH); both SHALL be derived from registered state only.
REQ-014 Overrun: an attempted push that is not accepted (full=1, no pop) SHALL discard the frame, leave the contents unchanged, and set overrun=1 on the next edge.
REQ-015 overrun_clr=1 SHALL clear overrun; if a new overrun occurs in the same cycle, set SHALL win.
REQ-016 flush=1 SHALL, on the next edge, zero both pointers and level, overriding any push or pop in that cycle; overrun SHALL be unaffected.
REQ-017 rxwm_irq SHALL be registered and equal (level > watermark) as evaluated on the post-update level; watermark >= DEPTH SHALL keep rxwm_irq=0.
REQ-018 rx_done is a strobe: each cycle with rx_done=1 SHALL count as exactly one push attempt, including back-to-back cycles.

Reset
REQ-019 reset=1 at a clock edge SHALL, at that edge, zero both pointers, level, overrun and rxwm_irq, and set empty=1, full=0, rd_data=0, rd_frame_error=0, rd_parity_error=0.
REQ-020 reset SHALL override flush, push, pop and overrun_clr in the same cycle.
REQ-021 Entry storage need not be reset; no output SHALL depend on unwritten entries.

Verification
REQ-022 A bench SHALL cover the following directed scenarios:
- Reset, then a push of 0xA5 with no errors -> next cycle: empty=0, level=1, rd_data=0xA5, flags 0; rd_en for one cycle -> empty=1, rd_data=0.
- DEPTH=8: push 0x00..0x07 -> full=1, level=8; push 0x08 -> overrun=1, contents unchanged; 8 pops return 0x00..0x07 in order; overrun_clr -> overrun=0.
- Full FIFO, push 0x55 together with rd_en -> head 0x00 popped, 0x55 stored, level stays 8, overrun=0; drain verifies pointer wrap-around order.
- drop_errored=1: push 0x11 with parity_error=1 -> level unchanged; drop_errored=0: same push -> entry stored, rd_parity_error=1, rd_data=0x11.
- watermark=2: third push -> rxwm_irq=1; one pop -> rxwm_irq=0; flush with rd_en and rx_done active -> level=0, empty=1, overrun unchanged.
- Reset asserted with 5 entries, overrun=1 and rx_done=1 in the same cycle -> level=0, empty=1, overrun=0, rxwm_irq=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side FIFO placed between a UART receiver and a bus interface.
//   Each entry holds {parity_error, frame_error, data[7:0]}. The read side is
//   show-ahead: the head entry is always visible on rd_* while the FIFO is
//   non-empty, and rd_* read as zero while it is empty.
//
// Ports
//   clock, reset         sole clock; synchronous active-high reset
//   rx_done              one-cycle frame-complete strobe (one push attempt per cycle)
//   rx_data              received byte, valid with rx_done
//   rx_frame_error       stop-bit error of the frame, valid with rx_done
//   rx_parity_error      parity error of the frame, valid with rx_done
//   drop_errored         discard frames carrying either error flag
//   flush                empty the FIFO (overrun is left alone)
//   rd_en                pop request; ignored while empty
//   rd_data              head byte (0 when empty)
//   rd_frame_error       head frame error (0 when empty)
//   rd_parity_error      head parity error (0 when empty)
//   empty, full          level == 0 / level == DEPTH
//   level                number of stored entries, 0..DEPTH
//   watermark            interrupt threshold
//   rxwm_irq             registered (level > watermark)
//   overrun              sticky: a push was attempted while full with no pop
//   overrun_clr          clears overrun; a same-cycle overrun wins

module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  input  logic          rx_frame_error,
  input  logic          rx_parity_error,
  input  logic          drop_errored,
  input  logic          flush,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_frame_error,
  output logic          rd_parity_error,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level,
  input  logic [LW-1:0] watermark,
  output logic          rxwm_irq,
  output logic          overrun,
  input  logic          overrun_clr
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic [9:0]    head;
  logic          push_try;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

  always_comb begin
    push_try = rx_done & ~(drop_errored & (rx_frame_error | rx_parity_error));
    pop_ok   = rd_en & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push_try & (~full | pop_ok);
    ovf      = push_try & full & ~pop_ok;
  end

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   level_next = level + 1'b1;
        2'b01:   level_next = level - 1'b1;
        default: level_next = level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overrun  <= 1'b0;
      rxwm_irq <= 1'b0;
    end else begin
      level <= level_next;
      // level never exceeds DEPTH, so watermark >= DEPTH holds the irq low.
      rxwm_irq <= (level_next > watermark);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (ovf) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Storage carries no reset; outputs only ever look at written entries.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push_ok) begin
      mem[wr_ptr] <= {rx_parity_error, rx_frame_error, rx_data};
    end
  end

  assign head            = mem[rd_ptr];
  assign rd_data         = empty ? 8'h00 : head[7:0];
  assign rd_frame_error  = empty ? 1'b0  : head[8];
  assign rd_parity_error = empty ? 1'b0  : head[9];

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_frame_error = 1'b0;
  logic          rx_parity_error = 1'b0;
  logic          drop_errored = 1'b0;
  logic          flush = 1'b0;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_frame_error;
  logic          rd_parity_error;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic [LW-1:0] watermark = LW'(DEPTH);
  logic          rxwm_irq;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {parity_error, frame_error, data}
  logic [9:0] sb[$];
  logic       m_ovr = 1'b0;
  logic       m_irq = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clock(clock), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .rx_frame_error(rx_frame_error), .rx_parity_error(rx_parity_error),
    .drop_errored(drop_errored), .flush(flush), .rd_en(rd_en),
    .rd_data(rd_data), .rd_frame_error(rd_frame_error),
    .rd_parity_error(rd_parity_error), .empty(empty), .full(full),
    .level(level), .watermark(watermark), .rxwm_irq(rxwm_irq),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [9:0] h;
    h = (sb.size() != 0) ? sb[0] : 10'h000;
    check({tag, ".level"},   32'(level),    32'(sb.size()));
    check({tag, ".empty"},   32'(empty),    32'(sb.size() == 0));
    check({tag, ".full"},    32'(full),     32'(sb.size() == DEPTH));
    check({tag, ".overrun"}, 32'(overrun),  32'(m_ovr));
    check({tag, ".irq"},     32'(rxwm_irq), 32'(m_irq));
    check({tag, ".head"}, 32'({rd_parity_error, rd_frame_error, rd_data}), 32'(h));
  endtask

  // One clock cycle of stimulus, with the model updated from pre-edge state.
  task automatic cyc(input string tag, input logic done, input logic [7:0] d,
                     input logic fe, input logic pe, input logic rd,
                     input logic fl, input logic oc);
    logic pop, try_push, is_full, ovf;
    rx_done = done; rx_data = d; rx_frame_error = fe; rx_parity_error = pe;
    rd_en = rd; flush = fl; overrun_clr = oc;
    pop      = rd && (sb.size() != 0);
    try_push = done && !(drop_errored && (fe || pe));
    is_full  = (sb.size() == DEPTH);
    ovf      = try_push && is_full && !pop;
    if (pop) check({tag, ".pop"}, 32'({rd_parity_error, rd_frame_error, rd_data}), 32'(sb[0]));
    if (fl) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (try_push && (!is_full || pop)) sb.push_back({pe, fe, d});
    end
    if (ovf) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
    m_irq = (sb.size() > int'(watermark));
    @(posedge clock); #1;
    rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
    rx_frame_error = 1'b0; rx_parity_error = 1'b0;
    check_state(tag);
  endtask

  task automatic push(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    cyc(tag, 1'b1, d, fe, pe, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1(input string tag);
    cyc(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Reset with push/pop/flush/overrun_clr all active: reset must win.
  task automatic do_reset(input string tag);
    reset = 1'b1; rx_done = 1'b1; rx_data = 8'hEE; rd_en = 1'b1;
    flush = 1'b1; overrun_clr = 1'b1;
    sb.delete(); m_ovr = 1'b0; m_irq = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    do_reset("reset0");

    // Single entry: show-ahead in the cycle after rx_done, then pop.
    push("pushA5", 8'hA5, 1'b0, 1'b0);
    pop1("popA5");
    pop1("pop_empty");

    // Fill (watermark = DEPTH keeps irq low), overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) push("fill", 8'(i), 1'b0, 1'b0);
    push("ovf08", 8'h08, 1'b0, 1'b0);
    cyc("ovf_clr_set", 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop1("drain");
    cyc("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full plus simultaneous push and pop; drain shows pointer wrap.
    for (int i = 0; i < DEPTH; i++) push("fill2", 8'(i), 1'b0, 1'b0);
    cyc("push_pop_full", 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop1("drain2");

    // Errored frames: dropped, then stored with flags.
    drop_errored = 1'b1;
    push("drop11", 8'h11, 1'b0, 1'b1);
    push("dropfe", 8'h22, 1'b1, 1'b0);
    drop_errored = 1'b0;
    push("keep11", 8'h11, 1'b0, 1'b1);
    push("keepfe", 8'h33, 1'b1, 1'b0);
    pop1("pop11");
    pop1("popfe");

    // Watermark interrupt and flush.
    watermark = LW'(2);
    push("wm1", 8'h61, 1'b0, 1'b0);
    push("wm2", 8'h62, 1'b0, 1'b0);
    push("wm3", 8'h63, 1'b0, 1'b0);
    pop1("wm_pop");
    cyc("flush", 1'b1, 8'h64, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Flush leaves a set overrun alone.
    for (int i = 0; i < DEPTH; i++) push("fill3", 8'(8'h80 + i), 1'b0, 1'b0);
    push("ovf3", 8'hFF, 1'b0, 1'b0);
    cyc("flush_ovr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset with 5 entries, overrun set and rx_done active.
    for (int i = 0; i < 5; i++) push("fill5", 8'(8'hC0 + i), 1'b0, 1'b0);
    do_reset("reset5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
